// File: rtl/score_bcd_formatter.sv
// score_bcd_formatter: iterative double-dabble conversion of a 16-bit score into
// four saturated BCD digits, packed as active-low 7-segment bytes for display_7segment.
module score_bcd_formatter #(
   parameter bit BLANK_LZ = 1'b1,
   localparam int unsigned VAL_W = 16,
   localparam int unsigned NDIG  = 4,
   localparam int unsigned BCD_W = 4 * NDIG,
   localparam int unsigned PAT_W = 8 * NDIG
) (
   input  logic             CP,
   input  logic             RST,
   input  logic             start,
   input  logic [VAL_W-1:0] value,
   input  logic [NDIG-1:0]  dp_mask,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd,
   output logic             ovf,
   output logic [PAT_W-1:0] patten_out
);

   localparam int unsigned SCR_DIG = 5;
   localparam int unsigned SCR_W   = 4 * SCR_DIG;
   localparam int unsigned CNT_W   = 4;

   localparam logic [CNT_W-1:0] CNT_LAST   = '1;
   localparam logic [6:0]       SEG_BLANK  = 7'b1111111;
   localparam logic [PAT_W-1:0] PATTEN_RST = BLANK_LZ ? 32'hFFFF_FFC0 : 32'hC0C0_C0C0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_FMT  = 2'd2
   } state_t;

   state_t             state_q, state_nxt;
   logic [VAL_W-1:0]   shift_q, shift_nxt;
   logic [SCR_W-1:0]   scr_q, scr_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic [NDIG-1:0]    dp_q, dp_nxt;
   logic               busy_nxt, done_nxt, ovf_nxt;
   logic [BCD_W-1:0]   bcd_nxt;
   logic [PAT_W-1:0]   patten_nxt;

   logic [SCR_W-1:0]   scr_adj_c;
   logic               fmt_ovf_c;
   logic [BCD_W-1:0]   fmt_bcd_c;
   logic [PAT_W-1:0]   fmt_patten_c;
   logic               lead_c;

   // Active-low segment code {g,f,e,d,c,b,a} for one BCD digit
   function automatic logic [6:0] seg_code(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Add-3 correction of every scratch digit that is 5 or more
   always_comb begin
      scr_adj_c = scr_q;
      for (int unsigned k = 0; k < SCR_DIG; k++) begin
         if (scr_q[k*4 +: 4] >= 4'd5) begin
            scr_adj_c[k*4 +: 4] = scr_q[k*4 +: 4] + 4'd3;
         end
      end
   end

   // Saturate, blank leading zeros and pack the display bytes from the finished scratch
   always_comb begin
      fmt_ovf_c    = (scr_q[SCR_W-1 -: 4] != 4'd0);
      fmt_bcd_c    = fmt_ovf_c ? 16'h9999 : scr_q[BCD_W-1:0];
      lead_c       = 1'b1;
      fmt_patten_c = '0;
      for (int unsigned k = 0; k < NDIG; k++) begin
         lead_c = lead_c & (fmt_bcd_c[(NDIG-1-k)*4 +: 4] == 4'd0);
         fmt_patten_c[(NDIG-1-k)*8 +: 8] =
            {~dp_q[NDIG-1-k],
             (BLANK_LZ && !fmt_ovf_c && lead_c && (k != NDIG-1)) ?
                SEG_BLANK : seg_code(fmt_bcd_c[(NDIG-1-k)*4 +: 4])};
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt  = state_q;
      shift_nxt  = shift_q;
      scr_nxt    = scr_q;
      cnt_nxt    = cnt_q;
      dp_nxt     = dp_q;
      busy_nxt   = busy;
      done_nxt   = 1'b0;
      bcd_nxt    = bcd;
      ovf_nxt    = ovf;
      patten_nxt = patten_out;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               shift_nxt = value;
               dp_nxt    = dp_mask;
               scr_nxt   = '0;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = S_CONV;
            end
         end
         S_CONV: begin
            {scr_nxt, shift_nxt} = {scr_adj_c[SCR_W-2:0], shift_q, 1'b0};
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_nxt = S_FMT;
            end
         end
         S_FMT: begin
            bcd_nxt    = fmt_bcd_c;
            ovf_nxt    = fmt_ovf_c;
            patten_nxt = fmt_patten_c;
            done_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            state_nxt  = S_IDLE;
         end
         default: begin
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge CP) begin
      if (RST) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         scr_q      <= '0;
         cnt_q      <= '0;
         dp_q       <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         bcd        <= '0;
         ovf        <= 1'b0;
         patten_out <= PATTEN_RST;
      end else begin
         state_q    <= state_nxt;
         shift_q    <= shift_nxt;
         scr_q      <= scr_nxt;
         cnt_q      <= cnt_nxt;
         dp_q       <= dp_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         bcd        <= bcd_nxt;
         ovf        <= ovf_nxt;
         patten_out <= patten_nxt;
      end
   end

endmodule

// File: tb/tb_score_bcd_formatter.sv
// Bench for score_bcd_formatter: one instance with leading-zero blanking, one without,
// both compared against an arithmetic reference model.
module tb_score_bcd_formatter;

   logic        CP = 1'b0;
   logic        RST;
   logic        start;
   logic [15:0] value;
   logic [3:0]  dp_mask;

   logic        busy1, done1, ovf1, busy0, done0, ovf0;
   logic [15:0] bcd1, bcd0;
   logic [31:0] pat1, pat0;

   int total = 0;
   int bad   = 0;

   logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

   score_bcd_formatter #(.BLANK_LZ(1'b1)) dut1 (
      .CP(CP), .RST(RST), .start(start), .value(value), .dp_mask(dp_mask),
      .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1), .patten_out(pat1));

   score_bcd_formatter #(.BLANK_LZ(1'b0)) dut0 (
      .CP(CP), .RST(RST), .start(start), .value(value), .dp_mask(dp_mask),
      .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0), .patten_out(pat0));

   always #5 CP = ~CP;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: saturate to 9999, split into decimal digits
   function automatic logic [15:0] ref_bcd(input int unsigned v);
      int unsigned n;
      n = (v > 9999) ? 9999 : v;
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   // Reference: display bytes; a leading digit blanks when the shown number is too short
   function automatic logic [31:0] ref_pat(input int unsigned v, input logic [3:0] dp,
                                           input bit blank_lz);
      int unsigned n;
      int unsigned dig;
      int unsigned lim;
      logic [31:0] p;
      n   = (v > 9999) ? 9999 : v;
      lim = 1;
      p   = '0;
      for (int i = 0; i < 4; i++) begin
         dig = (n / lim) % 10;
         if (blank_lz && i > 0 && n < lim)
            p[i*8 +: 8] = {~dp[i], 7'b1111111};
         else
            p[i*8 +: 8] = {~dp[i], seg_tab[dig]};
         lim = lim * 10;
      end
      return p;
   endfunction

   task automatic chk_result(input string tag, input int unsigned v, input logic [3:0] dp);
      chk({tag, "_bcd"}, 32'(bcd1), 32'(ref_bcd(v)));
      chk({tag, "_ovf"}, 32'(ovf1), 32'(v > 9999));
      chk({tag, "_pat1"}, pat1, ref_pat(v, dp, 1'b1));
      chk({tag, "_pat0"}, pat0, ref_pat(v, dp, 1'b0));
      chk({tag, "_bcd0"}, 32'(bcd0), 32'(ref_bcd(v)));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, 32'(busy1), 32'd0);
      chk({tag, "_done"}, 32'(done1), 32'd0);
      chk({tag, "_bcd"}, 32'(bcd1), 32'd0);
      chk({tag, "_ovf"}, 32'(ovf1), 32'd0);
      chk({tag, "_pat1"}, pat1, 32'hFFFF_FFC0);
      chk({tag, "_pat0"}, pat0, 32'hC0C0_C0C0);
   endtask

   // Count edges after E0 until done, bounded; busy must stay high until done
   task automatic wait_done(input int already, output int lat, output int gaps);
      lat  = already;
      gaps = 0;
      while (lat < 40) begin
         @(posedge CP); #1;
         lat++;
         if (done1) break;
         if (!busy1) gaps++;
      end
   endtask

   // One conversion from IDLE; inputs are scrambled right after acceptance
   task automatic run_conv(input string tag, input logic [15:0] v, input logic [3:0] dp);
      int lat, gaps;
      value = v; dp_mask = dp; start = 1'b1;
      @(posedge CP); #1;
      start = 1'b0; value = 16'($urandom); dp_mask = 4'($urandom);
      chk({tag, "_busy_e0"}, 32'(busy1), 32'd1);
      wait_done(0, lat, gaps);
      chk({tag, "_latency"}, 32'(lat), 32'd17);
      chk({tag, "_busy_gap"}, 32'(gaps), 32'd0);
      chk({tag, "_busy_fmt"}, 32'(busy1), 32'd0);
      chk({tag, "_done0"}, 32'(done0), 32'd1);
      chk_result(tag, 32'(v), dp);
      @(posedge CP); #1;
      chk({tag, "_done_width"}, 32'(done1), 32'd0);
      chk({tag, "_hold"}, pat1, ref_pat(32'(v), dp, 1'b1));
   endtask

   initial begin
      int lat, gaps, ndone;
      int dq[$];
      logic [15:0] rv;
      logic [3:0]  rd;

      RST = 1'b1; start = 1'b0; value = '0; dp_mask = '0;
      repeat (2) @(posedge CP);
      #1;
      chk_reset("reset");
      RST = 1'b0;
      @(posedge CP); #1;

      run_conv("v2048", 16'd2048, 4'b0000);
      run_conv("v7", 16'd7, 4'b0000);
      run_conv("v100dp", 16'd100, 4'b0010);
      run_conv("v0", 16'd0, 4'b1001);
      run_conv("v65535", 16'd65535, 4'b0000);
      run_conv("v9999", 16'd9999, 4'b0000);
      run_conv("v10000", 16'd10000, 4'b0101);
      run_conv("v10", 16'd10, 4'b1111);

      for (int i = 0; i < 16; i++) begin
         rv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9999));
         if (i < 4) rv = 16'($urandom_range(0, 120));
         rd = 4'($urandom);
         run_conv("rand", rv, rd);
      end

      // Start pulsed at E5 while converting must be ignored
      value = 16'd512; dp_mask = 4'b0000; start = 1'b1;
      @(posedge CP); #1;
      start = 1'b0;
      repeat (4) @(posedge CP);
      #1;
      value = 16'd4; start = 1'b1;
      @(posedge CP); #1;
      start = 1'b0;
      wait_done(5, lat, gaps);
      chk("ignore_latency", 32'(lat), 32'd17);
      chk_result("ignore", 32'd512, 4'b0000);
      @(posedge CP); #1;
      chk("ignore_idle", 32'(busy1), 32'd0);

      // Start held high: a new conversion every 18 clocks
      value = 16'd1234; dp_mask = 4'b0100; start = 1'b1;
      @(posedge CP); #1;
      for (int e = 1; e <= 53; e++) begin
         @(posedge CP); #1;
         if (done1) dq.push_back(e);
      end
      start = 1'b0;
      chk("held_count", 32'(dq.size()), 32'd3);
      for (int i = 0; i < dq.size(); i++) chk("held_edge", 32'(dq[i]), 32'(17 + 18 * i));
      chk_result("held", 32'd1234, 4'b0100);
      repeat (2) @(posedge CP);
      #1;
      chk("held_stop", 32'(busy1), 32'd0);

      // Reset at E8 aborts the conversion without a done
      value = 16'd1024; dp_mask = 4'b1111; start = 1'b1;
      @(posedge CP); #1;
      start = 1'b0;
      repeat (7) @(posedge CP);
      #1;
      RST = 1'b1;
      @(posedge CP); #1;
      RST = 1'b0;
      chk_reset("abort");
      ndone = 0;
      repeat (25) begin
         @(posedge CP); #1;
         if (done1 || busy1) ndone++;
      end
      chk("abort_quiet", 32'(ndone), 32'd0);
      run_conv("after_abort", 16'd16, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
